// File: rtl/apb_pkg.sv
// Shared APB constants, FSM state type and byte-lane merge helper.
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;

  localparam logic [APB_DATA_W-1:0] APB_ID_DEFAULT = 32'hA9B0_0001;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [APB_DATA_W-1:0] apb_strb_merge(
    input logic [APB_DATA_W-1:0] old_v,
    input logic [APB_DATA_W-1:0] new_v,
    input logic [APB_STRB_W-1:0] strb
  );
    logic [APB_DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < APB_STRB_W; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// NREGS x 32-bit register storage: byte-strobed write, combinational read.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int NREGS = 16,
  localparam int IDXW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDXW-1:0]       widx,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [APB_STRB_W-1:0] wstrb,
  input  logic [IDXW-1:0]       ridx,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [NREGS-1:0][APB_DATA_W-1:0] mem_q;
  logic [NREGS-1:0][APB_DATA_W-1:0] mem_d;

  // Next storage contents: merge the strobed lanes into the written word.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[widx] = apb_strb_merge(mem_q[widx], wdata, wstrb);
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage flops, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer with a small register file, wait states and error reporting.
// The top register reads as ID_VALUE and rejects writes.
// Optional macro APB_PROT_CHECK_EN: unprivileged accesses to the upper
// half of the register space complete with an error.
module apb_completer_regs
  import apb_pkg::*;
#(
  parameter int                    NREGS       = 16,
  parameter int                    WAIT_CYCLES = 0,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = APB_ID_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_STRB_W-1:0] PSTRB,
  input  logic [2:0]            PPROT,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int                    IDXW       = $clog2(NREGS);
  localparam logic [IDXW-1:0]       ID_IDX     = IDXW'(NREGS - 1);
  localparam logic [3:0]            WAIT_LD    = 4'(WAIT_CYCLES);
  localparam logic [APB_ADDR_W-1:0] ADDR_LIMIT = APB_ADDR_W'(4 * NREGS);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDXW-1:0]       idx_s;
  logic                  oor_s;
  logic                  id_hit_s;
  logic                  prot_err_s;
  logic                  err_s;
  logic                  ready_s;
  logic                  we_s;
  logic [APB_DATA_W-1:0] reg_rdata_s;
  logic                  unused_s;

  // Address decode; byte offset bits are ignored.
  assign idx_s    = PADDR[IDXW+1:2];
  assign oor_s    = (PADDR >= ADDR_LIMIT);
  assign id_hit_s = (idx_s == ID_IDX);
  assign unused_s = ^{PPROT, PADDR[1:0]};

`ifdef APB_PROT_CHECK_EN
  // Upper half of the index space requires a privileged access.
  assign prot_err_s = idx_s[IDXW-1] & ~PPROT[0];
`else
  assign prot_err_s = 1'b0;
`endif

  assign err_s   = oor_s | (PWRITE & id_hit_s) | prot_err_s;
  assign ready_s = (state_q == ACCESS) & PSEL & PENABLE & (cnt_q == 4'd0);
  assign we_s    = ready_s & PWRITE & ~err_s;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = WAIT_LD;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Initiator abandoned the transfer: no register update.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (!PENABLE) begin
          // A fresh setup phase restarts the wait sequence.
          state_d = ACCESS;
          cnt_d   = WAIT_LD;
        end else if (cnt_q != 4'd0) begin
          state_d = ACCESS;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          // Completion edge; the next setup is accepted from IDLE.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read data is driven only on a successful completing read.
  always_comb begin
    PRDATA = '0;
    if (ready_s && !PWRITE && !err_s) begin
      if (id_hit_s) begin
        PRDATA = ID_VALUE;
      end else begin
        PRDATA = reg_rdata_s;
      end
    end else begin
      PRDATA = '0;
    end
  end

  assign PREADY  = ready_s;
  assign PSLVERR = ready_s & err_s;

  apb_regfile #(
    .NREGS (NREGS)
  ) u_regfile (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (we_s),
    .widx  (idx_s),
    .wdata (PWDATA),
    .wstrb (PSTRB),
    .ridx  (idx_s),
    .rdata (reg_rdata_s)
  );

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: three instances (0, 3 and 2 wait states)
// against a transaction-level model, plus directed literal checks.
module tb_apb_completer_regs;

  localparam int N  = 16;
  localparam int ND = 3;
  localparam logic [31:0] IDV = 32'hA9B0_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        preset  [ND];
  logic        psel    [ND];
  logic        penable [ND];
  logic        pwrite  [ND];
  logic [31:0] paddr   [ND];
  logic [31:0] pwdata  [ND];
  logic [3:0]  pstrb   [ND];
  logic [2:0]  pprot   [ND];
  logic [31:0] prdata  [ND];
  logic        pready  [ND];
  logic        pslverr [ND];

  int total = 0;
  int bad   = 0;
  logic armed = 1'b0;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    apb_completer_regs #(
      .NREGS       (N),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
      .ID_VALUE    (32'hA9B0_0001)
    ) u_dut (
      .PCLK    (clk),
      .PRESET  (preset[g]),
      .PSEL    (psel[g]),
      .PENABLE (penable[g]),
      .PWRITE  (pwrite[g]),
      .PADDR   (paddr[g]),
      .PWDATA  (pwdata[g]),
      .PSTRB   (pstrb[g]),
      .PPROT   (pprot[g]),
      .PRDATA  (prdata[g]),
      .PREADY  (pready[g]),
      .PSLVERR (pslverr[g])
    );
  end

  // ---------------- reference model ----------------
  logic [ND-1:0][N-1:0][31:0] m_mem;
  logic [ND-1:0]              m_act;   // a setup phase has been accepted
  logic [ND-1:0][7:0]         m_acc;   // access cycles already spent

  function automatic int wt(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic m_ready(input int k);
    return m_act[k] && psel[k] && penable[k] && (int'(m_acc[k]) == wt(k));
  endfunction

  function automatic logic m_err(input int k);
    int  idx;
    logic e;
    idx = int'(paddr[k][5:2]);
    e = (paddr[k] >= 32'd64) || (pwrite[k] && idx == N - 1);
`ifdef APB_PROT_CHECK_EN
    e = e || (idx >= N / 2 && !pprot[k][0]);
`endif
    return e;
  endfunction

  function automatic logic [31:0] m_rdata(input int k);
    int idx;
    idx = int'(paddr[k][5:2]);
    if (m_ready(k) && !pwrite[k] && !m_err(k)) begin
      return (idx == N - 1) ? IDV : m_mem[k][idx];
    end
    return 32'h0;
  endfunction

  // Model update: APB transfer bookkeeping and register writes.
  always @(posedge clk) begin
    for (int k = 0; k < ND; k++) begin
      if (preset[k]) begin
        m_act[k] <= 1'b0;
        m_acc[k] <= 8'd0;
        m_mem[k] <= '0;
      end else if (!m_act[k]) begin
        if (psel[k] && !penable[k]) begin
          m_act[k] <= 1'b1;
          m_acc[k] <= 8'd0;
        end
      end else if (!psel[k]) begin
        m_act[k] <= 1'b0;
      end else if (!penable[k]) begin
        m_acc[k] <= 8'd0;
      end else if (m_ready(k)) begin
        m_act[k] <= 1'b0;
        if (pwrite[k] && !m_err(k)) begin
          m_mem[k][paddr[k][5:2]] <= bmerge(m_mem[k][paddr[k][5:2]], pwdata[k], pstrb[k]);
        end
      end else begin
        m_acc[k] <= m_acc[k] + 8'd1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < ND; k++) begin
        check($sformatf("dut%0d pready", k), {31'd0, pready[k]}, {31'd0, m_ready(k)});
        check($sformatf("dut%0d pslverr", k), {31'd0, pslverr[k]},
              {31'd0, m_ready(k) & m_err(k)});
        check($sformatf("dut%0d prdata", k), prdata[k], m_rdata(k));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xfer(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p,
                      output logic [31:0] rd, output logic er, output int n, output int nz);
    logic done;
    @(posedge clk); #1;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
    paddr[k] = a; pwdata[k] = d; pstrb[k] = s; pprot[k] = p;
    @(posedge clk); #1;
    penable[k] = 1'b1;
    n = 2; nz = 0; rd = 32'h0; er = 1'b0; done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (pready[k]) begin
        rd = prdata[k]; er = pslverr[k]; done = 1'b1;
      end else begin
        if (prdata[k] !== 32'h0) nz++;
        @(posedge clk); #1;
        n++;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL dut%0d timeout: got no PREADY expected PREADY within 40 cycles", k);
    end
    @(posedge clk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  task automatic abort_xfer(input int k, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = 1'b1;
    paddr[k] = a; pwdata[k] = d; pstrb[k] = 4'hF; pprot[k] = 3'b001;
    @(posedge clk); #1;
    penable[k] = 1'b1;
    @(posedge clk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0;
  endtask

  task automatic pulse_reset(input int k);
    @(posedge clk); #1;
    preset[k] = 1'b1;
    @(posedge clk); #1;
    preset[k] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n, nz;

    for (int k = 0; k < ND; k++) begin
      preset[k] = 1'b1; psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
      paddr[k] = 32'h0; pwdata[k] = 32'h0; pstrb[k] = 4'h0; pprot[k] = 3'b000;
    end
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < ND; k++) preset[k] = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      check("reset pready", {31'd0, pready[k]}, 32'd0);
      check("reset pslverr", {31'd0, pslverr[k]}, 32'd0);
      check("reset prdata", prdata[k], 32'h0);
    end

    // Zero-wait write/read of one register.
    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, n, nz);
    check("wr04 cycles", n, 2);
    check("wr04 err", {31'd0, er}, 32'd0);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, rd, er, n, nz);
    check("rd04 cycles", n, 2);
    check("rd04 data", rd, 32'hDEADBEEF);
    check("rd04 err", {31'd0, er}, 32'd0);

    // Partial byte-lane write.
    xfer(0, 1'b1, 32'h08, 32'h11223344, 4'hF, 3'b001, rd, er, n, nz);
    xfer(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 3'b001, rd, er, n, nz);
    xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, n, nz);
    check("rd08 strobed", rd, 32'h11BB33DD);

    // Empty strobe leaves the register alone without error.
    xfer(0, 1'b1, 32'h0C, 32'h01020304, 4'hF, 3'b001, rd, er, n, nz);
    xfer(0, 1'b1, 32'h0D, 32'hFFFFFFFF, 4'h0, 3'b001, rd, er, n, nz);
    check("strb0 err", {31'd0, er}, 32'd0);
    xfer(0, 1'b0, 32'h0C, 32'h0, 4'hF, 3'b001, rd, er, n, nz);
    check("strb0 data", rd, 32'h01020304);

    // Out-of-range and ID register.
    xfer(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 3'b001, rd, er, n, nz);
    check("wr40 err", {31'd0, er}, 32'd1);
    xfer(0, 1'b1, 32'h3C, 32'h12345678, 4'hF, 3'b001, rd, er, n, nz);
    check("wr3c err", {31'd0, er}, 32'd1);
    xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b001, rd, er, n, nz);
    check("rd3c id", rd, 32'hA9B0_0001);
    check("rd3c err", {31'd0, er}, 32'd0);
    xfer(0, 1'b0, 32'h44, 32'h0, 4'h0, 3'b001, rd, er, n, nz);
    check("rd44 err", {31'd0, er}, 32'd1);
    check("rd44 data", rd, 32'h0);

`ifdef APB_PROT_CHECK_EN
    xfer(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, n, nz);
    check("prot0 err", {31'd0, er}, 32'd1);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, n, nz);
    check("prot0 unchanged", rd, 32'h0);
    xfer(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b001, rd, er, n, nz);
    check("prot1 err", {31'd0, er}, 32'd0);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er, n, nz);
    check("prot1 data", rd, 32'hCAFEF00D);
`endif

    // Three wait states.
    xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, 3'b001, rd, er, n, nz);
    check("wait3 cycles", n, 5);
    check("wait3 early prdata", nz, 0);
    check("wait3 data", rd, 32'h0);

    // Reset in the access phase of a write (two wait states).
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'h10; pwdata[2] = 32'h5A5A5A5A; pstrb[2] = 4'hF; pprot[2] = 3'b001;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    preset[2] = 1'b1;
    @(posedge clk); #1;
    preset[2] = 1'b0;
    @(negedge clk);
    check("post-reset idle", {31'd0, pready[2]}, 32'd0);
    @(posedge clk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    xfer(2, 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, rd, er, n, nz);
    check("reset abort data", rd, 32'h0);
    check("wait2 cycles", n, 4);

    // PSEL dropped mid-wait, then a normal transfer.
    abort_xfer(2, 32'h14, 32'h77778888);
    xfer(2, 1'b0, 32'h14, 32'h0, 4'h0, 3'b001, rd, er, n, nz);
    check("psel drop data", rd, 32'h0);
    xfer(2, 1'b1, 32'h14, 32'h13579BDF, 4'hF, 3'b001, rd, er, n, nz);
    xfer(2, 1'b0, 32'h14, 32'h0, 4'h0, 3'b001, rd, er, n, nz);
    check("after drop data", rd, 32'h13579BDF);

    // Randomised traffic, checked by the compare process.
    for (int k = 0; k < ND; k++) begin
      for (int i = 0; i < 50; i++) begin
        int r;
        logic [31:0] a;
        r = int'($urandom_range(0, 19));
        a = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
        if (r == 0 && k > 0) begin
          abort_xfer(k, a, $urandom);
        end else if (r == 1) begin
          pulse_reset(k);
        end else begin
          xfer(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 3'($urandom),
               rd, er, n, nz);
        end
      end
    end

    @(posedge clk); @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_completer_regs.md
APB_COMPLETER_REGS -- requirements
Module: apb_completer_regs

Interface
REQ-001 The block SHALL have parameter NREGS, default 16, giving the number of 32-bit registers (power of two, 4..64).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 0, giving the wait states inserted per access (0..15).
REQ-003 The block SHALL have parameter ID_VALUE, default 32'hA9B0_0001, giving the read-only content of register NREGS-1.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- PCLK  in  1  clock; all state changes on the rising edge
- PRESET  in  1  synchronous active-high reset
- PSEL  in  1  completer select
- PENABLE  in  1  access phase
- PWRITE  in  1  1=write, 0=read
- PADDR  in  32  byte address
- PWDATA  in  32  write data
- PSTRB  in  4  write byte lanes
- PPROT  in  3  protection type; bit0=privileged
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error

Function
REQ-005 The FSM SHALL have states IDLE and ACCESS.
REQ-006 IDLE SHALL go to ACCESS on PSEL=1, PENABLE=0, loading the wait counter with WAIT_CYCLES.
REQ-007 In ACCESS, with PSEL=1, PENABLE=1 and counter>0, the counter SHALL decrement by one per cycle.
REQ-008 PREADY SHALL be 1 only when state=ACCESS, PSEL=1, PENABLE=1 and counter=0; with WAIT_CYCLES=0 this gives zero wait states.
REQ-009 The transfer SHALL complete on the edge where PSEL, PENABLE and PREADY are all 1.
REQ-010 On completion with PSEL=1, PENABLE=0 (back-to-back setup) the FSM SHALL stay in ACCESS and reload the counter; otherwise it SHALL return to IDLE.
REQ-011 If PSEL drops while in ACCESS before completion, the FSM SHALL return to IDLE with no register update.
REQ-012 The register index SHALL be PADDR[log2(NREGS)+1:2]; PADDR[1:0] SHALL be ignored.
REQ-013 An address >= 4*NREGS SHALL be out of range.
REQ-014 Writes SHALL update only the byte lanes whose PSTRB bit is 1, at the completion edge; PSTRB=4'b0000 SHALL leave the register unchanged and return no error.
REQ-015 PRDATA SHALL carry the addressed register while PREADY=1 and PWRITE=0, and SHALL be 32'h0 otherwise; PSTRB SHALL be ignored on reads.
REQ-016 Register NREGS-1 SHALL read as ID_VALUE; a write to it SHALL be discarded and SHALL set PSLVERR.
REQ-017 PSLVERR SHALL be 1 only while PREADY=1 and the access is out of range, a write to the ID register, or a protection fault (REQ-021).
REQ-018 An erroring write SHALL modify no register; an erroring read SHALL return PRDATA=32'h0.

Reset
REQ-019 On PRESET=1 at a clock edge the block SHALL clear every register other than the ID register to 0, force state=IDLE, counter=0, PREADY=0, PSLVERR=0 and PRDATA=0.
REQ-020 A reset asserted mid-access SHALL abort the access with no register write; the initiator SHALL restart from its setup phase.

Configuration
REQ-021 With APB_PROT_CHECK_EN defined, an access to index >= NREGS/2 with PPROT[0]=0 SHALL complete with PSLVERR=1, no write and PRDATA=0.
REQ-022 Without APB_PROT_CHECK_EN, PPROT SHALL be ignored and all in-range indices SHALL be accessible.

Structure
REQ-023 Package apb_pkg SHALL hold the FSM state enum (IDLE, ACCESS), the APB data/address width constants and the default ID_VALUE.
REQ-024 Sub-module apb_regfile SHALL hold the NREGS×32 storage with byte-strobe write and combinational read; apb_completer_regs SHALL contain the FSM, wait counter, decode and error logic.

Verification
REQ-025 Write 32'hDEADBEEF to 0x04 (PSTRB=1111, WAIT_CYCLES=0), then read 0x04 -> each transfer completes in 2 cycles; PRDATA=32'hDEADBEEF, PSLVERR=0.
REQ-026 Write 32'h11223344 to 0x08, then write 32'hAABBCCDD with PSTRB=0101, then read 0x08 -> PRDATA=32'h11BB33DD.
REQ-027 WAIT_CYCLES=3, read 0x00 -> PREADY low for 3 access cycles and high on the 4th; PRDATA=0 before PREADY.
REQ-028 Write to 0x40 (NREGS=16), then write to 0x3C, then read 0x3C -> both writes give PSLVERR=1; the read returns 32'hA9B0_0001 with PSLVERR=0.
REQ-029 With APB_PROT_CHECK_EN, write 0x20 with PPROT=000 -> PSLVERR=1 and register unchanged; the same write with PPROT=001 -> PSLVERR=0 and data written.
REQ-030 WAIT_CYCLES=2: assert PRESET during the access phase of a write -> register stays 0 and state=IDLE; drop PSEL mid-wait -> no write, and the next setup is accepted normally.
